vga_scan_ctrl: RTL and testbench

- VGA 640x480@60 Hz timing generator. Sits directly upstream of the digit overlay renderer.
- Produces the scan address (vga_col, vga_row) that the renderer consumes.
- Samples the renderer's combinational pixel_data (bbbb_gggg_rrrr) and drives registered RGB and sync pins to the connector.
- The renderer's output is returned through pixel_data within the same pixel period.

---
 rtl/vga_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_vga_scan_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_ctrl.sv
// ---------------------------------------------------------------------------
// vga_scan_ctrl
// VGA 640x480@60 Hz timing generator. Divides the system clock down to the
// pixel rate, runs the horizontal/vertical scan counters, presents the
// visible scan address to the downstream renderer and registers the
// renderer's colour together with the sync pulses so both reach the
// connector with the same one-pixel latency.
//
// Build option:
//   VGA_BORDER_EN - when defined, the outermost visible rows and columns are
//                   forced to full white (4'hF on every channel), overriding
//                   pixel_data. When undefined, RGB is taken from pixel_data.
// ---------------------------------------------------------------------------
module vga_scan_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] pixel_data,
  output logic [9:0]  vga_col,
  output logic [8:0]  vga_row,
  output logic        pix_tick,
  output logic        video_on,
  output logic        frame_start,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST       = 10'(H_TOT - 1);
  localparam logic [9:0] H_VIS_END    = 10'(H_VIS);
  localparam logic [9:0] H_SYNC_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VIS + H_FP + H_SYNC);

  localparam logic [9:0] V_LAST       = 10'(V_TOT - 1);
  localparam logic [9:0] V_VIS_END    = 10'(V_VIS);
  localparam logic [9:0] V_SYNC_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VIS + V_FP + V_SYNC);

`ifdef VGA_BORDER_EN
  localparam logic [9:0] H_VIS_LAST   = 10'(H_VIS - 1);
  localparam logic [9:0] V_VIS_LAST   = 10'(V_VIS - 1);
`endif

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic             line_end;
  logic             frame_end;
  logic             hs_next;
  logic             vs_next;
  logic [11:0]      rgb_next;

  // The tick is decoded from the divider so it is already low in reset and
  // the first tick lands CLK_DIV clocks after release.
  assign pix_tick  = (div_cnt == DIV_LAST);
  assign line_end  = (h_cnt == H_LAST);
  assign frame_end = line_end && (v_cnt == V_LAST);

  assign video_on  = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
  assign vga_col   = video_on ? h_cnt : 10'd0;
  assign vga_row   = video_on ? v_cnt[8:0] : 9'd0;

  // Pixel-rate divider: counts 0..CLK_DIV-1 and wraps on the tick.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (pix_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Scan counters: advance one pixel per tick, wrap line then frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else if (pix_tick) begin
      if (line_end) begin
        h_cnt <= 10'd0;
        v_cnt <= frame_end ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Next values for the pin stage, decoded from the current scan position.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    hs_next  = 1'b1;
    vs_next  = 1'b1;
    rgb_next = 12'h000;
    if ((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END)) hs_next = 1'b0;
    if ((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END)) vs_next = 1'b0;
    if (video_on) begin
      rgb_next = pixel_data;
`ifdef VGA_BORDER_EN
      if ((h_cnt == 10'd0) || (h_cnt == H_VIS_LAST) ||
          (v_cnt == 10'd0) || (v_cnt == V_VIS_LAST)) begin
        rgb_next = 12'hFFF;
      end
`endif
    end
  end

  // Pin stage: colour and sync share one register stage so they stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs    <= 1'b1;
      vs    <= 1'b1;
      vga_r <= 4'h0;
      vga_g <= 4'h0;
      vga_b <= 4'h0;
    end else if (pix_tick) begin
      hs    <= hs_next;
      vs    <= vs_next;
      vga_r <= rgb_next[3:0];
      vga_g <= rgb_next[7:4];
      vga_b <= rgb_next[11:8];
    end
  end

  // One-clock frame marker in the clock after the last pixel of the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_tick && frame_end;
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_ctrl
// Directed bench for vga_scan_ctrl. A full-size instance checks reset, pixel
// and line timing, colour mapping, blanking and the sampling window; a
// shrunken-timing instance covers whole frames, vsync and frame_start in a
// short run. Expected values come from the position implied by the number
// of clock edges since reset release. Honours VGA_BORDER_EN.
// ---------------------------------------------------------------------------
module tb_vga_scan_ctrl;

  // Full-size timing
  localparam int D     = 4;
  localparam int HV    = 640;
  localparam int HT    = 800;
  localparam int VV    = 480;
  localparam int VT    = 525;
  localparam int HS_LO = 656;
  localparam int HS_HI = 752;
  localparam int VS_LO = 490;
  localparam int VS_HI = 492;

  // Shrunken timing: 8+2+3+3 = 16 pixels, 4+1+2+2 = 9 lines
  localparam int SD     = 2;
  localparam int SHV    = 8;
  localparam int SHT    = 16;
  localparam int SVV    = 4;
  localparam int SVT    = 9;
  localparam int SHS_LO = 10;
  localparam int SHS_HI = 13;
  localparam int SVS_LO = 5;
  localparam int SVS_HI = 7;
  localparam int SFR    = SHT * SVT;

`ifdef VGA_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst_s = 1'b0;
  logic [11:0] pixel_data = 12'h000;
  logic [11:0] pixel_data_s = 12'h000;

  logic [9:0] vga_col, vga_col_s;
  logic [8:0] vga_row, vga_row_s;
  logic       pix_tick, pix_tick_s;
  logic       video_on, video_on_s;
  logic       frame_start, frame_start_s;
  logic       hs, hs_s, vs, vs_s;
  logic [3:0] vga_r, vga_g, vga_b;
  logic [3:0] vga_r_s, vga_g_s, vga_b_s;

  always #5 clk = ~clk;

  vga_scan_ctrl #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .pixel_data(pixel_data),
    .vga_col(vga_col), .vga_row(vga_row), .pix_tick(pix_tick),
    .video_on(video_on), .frame_start(frame_start), .hs(hs), .vs(vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  vga_scan_ctrl #(
    .CLK_DIV(SD), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut_s (
    .clk(clk), .rst(rst_s), .pixel_data(pixel_data_s),
    .vga_col(vga_col_s), .vga_row(vga_row_s), .pix_tick(pix_tick_s),
    .video_on(video_on_s), .frame_start(frame_start_s), .hs(hs_s), .vs(vs_s),
    .vga_r(vga_r_s), .vga_g(vga_g_s), .vga_b(vga_b_s)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Renderer stand-in for the full-size instance: green left half, red right
  // half, white in blanking (which must never reach the pins).
  function automatic logic [11:0] pd_true(input int h);
    if (h < 320) return 12'h0F0;
    if (h < HV)  return 12'h00F;
    return 12'hFFF;
  endfunction

  // Expected {b,g,r} for a position that has been through the pin stage.
  function automatic logic [11:0] exp_rgb(input int h, input int v, input int hv,
                                          input int vv, input logic [11:0] pd);
    if (!(h < hv && v < vv)) return 12'h000;
    if (BORDER && (h == 0 || h == hv - 1 || v == 0 || v == vv - 1)) return 12'hFFF;
    return pd;
  endfunction

  initial begin
    int bad_tick, bad_col, bad_row, bad_von, bad_hs, bad_vs, bad_rgb, bad_fs;
    int hs_low, first_hs, second_hs, n_tick, fs_cnt, fs_first, fs_second, vs_low;
    int pos, hc, vc, ph, pv;
    logic        prev_hs, ehs, evs, vis;
    logic [11:0] erg;
    bit          found;

    // ---- Reset with no clock edge yet ----
    #1 rst = 1'b1; rst_s = 1'b1;
    #2;
    check("rst.pix_tick",    pix_tick, 0);
    check("rst.frame_start", frame_start, 0);
    check("rst.hs",          hs, 1);
    check("rst.vs",          vs, 1);
    check("rst.rgb",         {vga_b, vga_g, vga_r}, 12'h000);
    check("rst.video_on",    video_on, 1);
    check("rst.vga_col",     vga_col, 0);
    check("rst.vga_row",     vga_row, 0);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // ---- Two full lines on the full-size instance ----
    bad_tick = 0; bad_col = 0; bad_row = 0; bad_von = 0;
    bad_hs = 0; bad_vs = 0; bad_rgb = 0; bad_fs = 0;
    hs_low = 0; first_hs = -1; second_hs = -1; n_tick = 0; prev_hs = 1'b1;
    for (int k = 1; k <= 2 * HT * D + 8; k++) begin
      // Only the value present at a tick edge may matter; junk elsewhere.
      if (k % D == 0) pixel_data = pd_true((k / D - 1) % HT);
      else            pixel_data = 12'($urandom);
      @(negedge clk);
      pos = k / D;
      hc  = pos % HT;
      vc  = (pos / HT) % VT;
      vis = (hc < HV) && (vc < VV);
      if (pix_tick !== 1'((k % D) == D - 1)) bad_tick++;
      if (pix_tick === 1'b1) n_tick++;
      if (video_on !== vis) bad_von++;
      if (vga_col !== 10'(vis ? hc : 0)) bad_col++;
      if (vga_row !== 9'(vis ? vc : 0)) bad_row++;
      if (pos >= 1) begin
        ph  = (pos - 1) % HT;
        pv  = ((pos - 1) / HT) % VT;
        ehs = !(ph >= HS_LO && ph < HS_HI);
        evs = !(pv >= VS_LO && pv < VS_HI);
        erg = exp_rgb(ph, pv, HV, VV, pd_true(ph));
      end else begin
        ehs = 1'b1; evs = 1'b1; erg = 12'h000;
      end
      if (hs !== ehs) bad_hs++;
      if (vs !== evs) bad_vs++;
      if ({vga_b, vga_g, vga_r} !== erg) bad_rgb++;
      if (frame_start !== 1'b0) bad_fs++;
      if (hs === 1'b0) hs_low++;
      if (prev_hs === 1'b1 && hs === 1'b0) begin
        if (first_hs < 0) first_hs = k;
        else if (second_hs < 0) second_hs = k;
      end
      prev_hs = hs;
      // Hand-picked points: (10,1) green, (330,1) red, (699,1) blank
      if (k == 3244) check("colour.green", {vga_b, vga_g, vga_r}, 12'h0F0);
      if (k == 4524) check("colour.red",   {vga_b, vga_g, vga_r}, 12'h00F);
      if (k == 6000) begin
        check("blank.rgb",      {vga_b, vga_g, vga_r}, 12'h000);
        check("blank.video_on", video_on, 0);
        check("blank.vga_col",  vga_col, 0);
        check("blank.vga_row",  vga_row, 0);
      end
    end
    check("line.pix_tick mismatches", bad_tick, 0);
    check("line.video_on mismatches", bad_von, 0);
    check("line.vga_col mismatches",  bad_col, 0);
    check("line.vga_row mismatches",  bad_row, 0);
    check("line.hs mismatches",       bad_hs, 0);
    check("line.vs mismatches",       bad_vs, 0);
    check("line.rgb mismatches",      bad_rgb, 0);
    check("line.frame_start highs",   bad_fs, 0);
    check("line.tick count",          n_tick, 2 * HT + 2);
    check("line.hs low clocks",       hs_low, 2 * 96 * D);
    check("line.hs first fall clk",   first_hs, (HS_LO + 1) * D);
    check("line.hs period clks",      second_hs - first_hs, HT * D);

    // Now at (2,2) with pins holding (1,2)
    check("colour.g_only", {vga_b, vga_g, vga_r}, 12'h0F0);

    // ---- Asynchronous reset mid-line at column 300 ----
    pixel_data = 12'h0F0;
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (vga_col == 10'd300) begin
        found = 1'b1;
        break;
      end
    end
    check("midrst.reached col 300", found, 1);
    check("midrst.row before",      vga_row, 2);
    check("midrst.rgb before",      {vga_b, vga_g, vga_r}, 12'h0F0);
    #2 rst = 1'b1;
    #1;
    check("midrst.rgb async",      {vga_b, vga_g, vga_r}, 12'h000);
    check("midrst.hs async",       hs, 1);
    check("midrst.vs async",       vs, 1);
    check("midrst.pix_tick async", pix_tick, 0);
    check("midrst.vga_col async",  vga_col, 0);
    @(negedge clk);
    check("midrst.pix_tick held", pix_tick, 0);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("release.pix_tick", pix_tick, (i == 3) ? 1 : 0);
      if (i == 3) begin
        check("release.vga_col", vga_col, 0);
        check("release.vga_row", vga_row, 0);
        check("release.rgb",     {vga_b, vga_g, vga_r}, 12'h000);
      end
    end

    // ---- Two frames on the shrunken instance ----
    rst_s = 1'b0;
    bad_tick = 0; bad_col = 0; bad_row = 0; bad_von = 0;
    bad_hs = 0; bad_vs = 0; bad_rgb = 0; bad_fs = 0;
    fs_cnt = 0; fs_first = -1; fs_second = -1; vs_low = 0;
    for (int k = 1; k <= 2 * SFR * SD + 6; k++) begin
      if (k % SD == 0) pixel_data_s = 12'h000;
      else             pixel_data_s = 12'($urandom) | 12'h111;
      @(negedge clk);
      pos = k / SD;
      hc  = pos % SHT;
      vc  = (pos / SHT) % SVT;
      vis = (hc < SHV) && (vc < SVV);
      if (pix_tick_s !== 1'((k % SD) == SD - 1)) bad_tick++;
      if (video_on_s !== vis) bad_von++;
      if (vga_col_s !== 10'(vis ? hc : 0)) bad_col++;
      if (vga_row_s !== 9'(vis ? vc : 0)) bad_row++;
      if (pos >= 1) begin
        ph  = (pos - 1) % SHT;
        pv  = ((pos - 1) / SHT) % SVT;
        ehs = !(ph >= SHS_LO && ph < SHS_HI);
        evs = !(pv >= SVS_LO && pv < SVS_HI);
        erg = exp_rgb(ph, pv, SHV, SVV, 12'h000);
      end else begin
        ehs = 1'b1; evs = 1'b1; erg = 12'h000;
      end
      if (hs_s !== ehs) bad_hs++;
      if (vs_s !== evs) bad_vs++;
      if ({vga_b_s, vga_g_s, vga_r_s} !== erg) bad_rgb++;
      if (frame_start_s !== 1'((k % SD == 0) && ((k / SD - 1) % SFR == SFR - 1))) bad_fs++;
      if (vs_s === 1'b0) vs_low++;
      if (frame_start_s === 1'b1) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = k;
        else if (fs_second < 0) fs_second = k;
      end
    end
    check("frame.pix_tick mismatches",    bad_tick, 0);
    check("frame.video_on mismatches",    bad_von, 0);
    check("frame.vga_col mismatches",     bad_col, 0);
    check("frame.vga_row mismatches",     bad_row, 0);
    check("frame.hs mismatches",          bad_hs, 0);
    check("frame.vs mismatches",          bad_vs, 0);
    check("frame.rgb/border mismatches",  bad_rgb, 0);
    check("frame.frame_start mismatches", bad_fs, 0);
    check("frame.frame_start clocks",     fs_cnt, 2);
    check("frame.first frame_start clk",  fs_first, SFR * SD);
    check("frame.frame_start period",     fs_second - fs_first, SFR * SD);
    check("frame.vs low clocks",          vs_low, 2 * 2 * SHT * SD);

    // ---- Asynchronous reset while both syncs are active ----
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (hs_s === 1'b0 && vs_s === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check("syncrst.reached hs&vs low", found, 1);
    #2 rst_s = 1'b1;
    #1;
    check("syncrst.hs async",       hs_s, 1);
    check("syncrst.vs async",       vs_s, 1);
    check("syncrst.pix_tick async", pix_tick_s, 0);
    check("syncrst.rgb async",      {vga_b_s, vga_g_s, vga_r_s}, 12'h000);
    @(negedge clk);
    rst_s = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
